// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 operation codes, FSM state encodings and operation-class predicates.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide sequencer (slave), including flush and the stall output.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath: shift-add multiply / restoring divide on operand
// magnitudes, sequenced by start/step/finish strobes, with final sign fix.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            early_i,
  input  logic [XLEN-1:0] early_res_i,
  input  logic            step_i,
  input  logic            finish_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int AW = 2 * XLEN + 1;

  logic [AW-1:0]     acc_q;
  logic [XLEN-1:0]   opnd_q;
  md_op_e            op_q;
  logic              prod_neg_q;
  logic              rem_neg_q;
  logic              early_q;
  logic [XLEN-1:0]   result_q;

  logic              sa_s;
  logic              sb_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     addend_s;
  logic [XLEN:0]     sum_s;
  logic [AW-1:0]     mul_next_s;
  logic [AW-1:0]     shifted_s;
  logic [XLEN:0]     diff_s;
  logic [AW-1:0]     div_next_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   final_s;

  // Operand magnitudes and one multiply or divide iteration.
  always_comb begin
    sa_s    = is_signed_a(op_i) & a_i[XLEN-1];
    sb_s    = is_signed_b(op_i) & b_i[XLEN-1];
    mag_a_s = sa_s ? (XLEN'(0) - a_i) : a_i;
    mag_b_s = sb_s ? (XLEN'(0) - b_i) : b_i;

    addend_s   = acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}};
    sum_s      = acc_q[AW-1:XLEN] + addend_s;
    mul_next_s = {1'b0, sum_s, acc_q[XLEN-1:1]};

    // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    shifted_s  = {acc_q[AW-2:0], 1'b0};
    diff_s     = shifted_s[AW-1:XLEN] - {1'b0, opnd_q};
    div_next_s = diff_s[XLEN] ? shifted_s : {diff_s, shifted_s[XLEN-1:1], 1'b1};
  end

  // Sign correction and result selection at completion.
  always_comb begin
    prod_fix_s = prod_neg_q ? ((2*XLEN)'(0) - acc_q[2*XLEN-1:0]) : acc_q[2*XLEN-1:0];
    quo_fix_s  = prod_neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix_s  = rem_neg_q ? (XLEN'(0) - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (early_q) begin
      final_s = acc_q[2*XLEN-1:XLEN];
    end else begin
      case (op_q)
        MD_MUL:                       final_s = prod_fix_s[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: final_s = prod_fix_s[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:              final_s = quo_fix_s;
        MD_REM, MD_REMU:              final_s = rem_fix_s;
        default:                      final_s = {XLEN{1'b0}};
      endcase
    end
  end

  // Datapath state: load on start, iterate on step, publish on finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= {AW{1'b0}};
      opnd_q     <= {XLEN{1'b0}};
      op_q       <= MD_MUL;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      early_q    <= 1'b0;
      result_q   <= {XLEN{1'b0}};
    end else begin
      if (start_i) begin
        op_q       <= md_op_e'(op_i);
        opnd_q     <= mag_b_s;
        early_q    <= early_i;
        // Division by zero keeps the all-ones quotient unsigned.
        prod_neg_q <= (sa_s ^ sb_s) & ~(is_div(op_i) & (b_i == {XLEN{1'b0}}));
        rem_neg_q  <= sa_s;
        acc_q      <= early_i ? {1'b0, early_res_i, {XLEN{1'b0}}}
                              : {{(XLEN+1){1'b0}}, mag_a_s};
      end else if (step_i) begin
        acc_q <= is_div(op_q) ? div_next_s : mul_next_s;
      end
      if (finish_i) begin
        result_q <= final_s;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter and handshakes.
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip the iterations entirely.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q;
  logic             busy_q;
  logic             start_s;
  logic             step_s;
  logic             finish_s;
  logic             early_hit_s;
  logic [XLEN-1:0]  early_res_s;
  logic [XLEN-1:0]  result_s;

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf_s;

  // Results known without iterating: zero operands and signed overflow.
  always_comb begin
    ovf_s = is_div(bus.op) & is_signed_a(bus.op)
          & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
    early_hit_s = (bus.a == {XLEN{1'b0}}) | (bus.b == {XLEN{1'b0}}) | ovf_s;
    if (!is_div(bus.op)) begin
      early_res_s = {XLEN{1'b0}};
    end else if (bus.b == {XLEN{1'b0}}) begin
      early_res_s = is_rem(bus.op) ? bus.a : {XLEN{1'b1}};
    end else if (ovf_s) begin
      early_res_s = is_rem(bus.op) ? {XLEN{1'b0}} : bus.a;
    end else begin
      early_res_s = {XLEN{1'b0}};
    end
  end
`else
  assign early_hit_s = 1'b0;
  assign early_res_s = {XLEN{1'b0}};
`endif

  // Next-state logic; the first DONE cycle applies the sign fix before out_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    start_s     = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          start_s = 1'b1;
          if (early_hit_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(XLEN);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          step_s = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DONE: begin
        if (bus.flush) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else if (!out_valid_q) begin
          finish_s    = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered handshake/stall outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  muldiv_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_s),
    .early_i     (early_hit_s),
    .early_res_i (early_res_s),
    .step_i      (step_s),
    .finish_i    (finish_s),
    .op_i        (bus.op),
    .a_i         (bus.a),
    .b_i         (bus.b),
    .result_o    (result_s)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_s;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result and latency are queued at
// issue time from a 64-bit arithmetic model and compared when out_valid rises.
module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb;
    logic ovf;
    logic [31:0] r;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = {{32{a[31] & (op != OP_MULHU)}}, a};
    eb  = {{32{b[31] & ((op == OP_MUL) || (op == OP_MULH))}}, b};
    p   = ea * eb;
    case (op)
      OP_MUL:  r = p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = p[63:32];
      OP_DIV:  r = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      OP_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  r = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      OP_REMU: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int l;
    l = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if ((a == 32'd0) || (b == 32'd0) ||
        (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
      l = 1;
`endif
    return l;
  endfunction

  // Drive one request; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int g;
    if (push) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
    end
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] res, output int lat, output bit ok);
    ok = 1'b0; lat = 0; res = 32'hx;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i; res = bus.out_result; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 32'd0) begin n_bad++; $display("FAIL reset_out_result: got %h required 0", bus.out_result); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  // Issue a table of ops one by one and check result and latency.
  task automatic run_table(input string tag, input logic [2:0] ops[$], input logic [31:0] as[$], input logic [31:0] bs[$]);
    logic [31:0] r, e;
    int l, el;
    bit ok;
    for (int i = 0; i < ops.size(); i++) begin
      send(ops[i], as[i], bs[i], 1'b1);
      collect(r, l, ok);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++;
      if (!ok || r !== e) begin
        n_bad++;
        $display("FAIL %s_result[%0d] op=%0d a=%h b=%h: got %h required %h", tag, i, ops[i], as[i], bs[i], r, e);
      end
      n_cmp++;
      if (l !== el) begin
        n_bad++;
        $display("FAIL %s_latency[%0d]: got %0d required %0d", tag, i, l, el);
      end
      release_out();
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops[$] = '{OP_MULH, OP_MUL, OP_MULHSU, OP_MULHU, OP_MUL, OP_MULH, OP_MULHSU};
    logic [31:0] as[$]  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFF9, 32'h0000_0005};
    logic [31:0] bs[$]  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h9ABC_DEF0, 32'h0000_0003, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      ops.push_back(3'(i));
      as.push_back($urandom);
      bs.push_back($urandom);
    end
    run_table("mul", ops, as, bs);
  endtask

  task automatic test_div();
    logic [2:0]  ops[$] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as[$]  = '{32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0007, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs[$]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002,
                            32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h0000_0005, 32'h0000_000A};
    for (int i = 4; i < 8; i++) begin
      ops.push_back(3'(i));
      as.push_back($urandom);
      bs.push_back($urandom_range(1, 32'h0001_0000));
    end
    run_table("div", ops, as, bs);
  endtask

  task automatic test_backpressure();
    logic [31:0] r, e, held;
    int l, el;
    bit ok;
    int bad_hold;
    send(OP_MUL, 32'h0001_0003, 32'h0000_0101, 1'b1);
    collect(r, l, ok);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    n_cmp++; if (!ok || r !== e) begin n_bad++; $display("FAIL bp_result: got %h required %h", r, e); end
    n_cmp++; if (l !== el) begin n_bad++; $display("FAIL bp_latency: got %0d required %0d", l, el); end
    held = bus.out_result;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_result !== held || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
        bad_hold++;
    end
    n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad_hold); end
    release_out();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b required 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] r, e;
    int l, el, spurious;
    bit ok;
    @(negedge clk);
    bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_vs_accept: got busy=%b required 0", bus.busy); end

    send(OP_MUL, 32'd9, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_busy: got busy=%b valid=%b ready=%b required 0/0/1", bus.busy, bus.out_valid, bus.in_ready);
    end

    send(OP_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'd0) begin
      n_bad++; $display("FAIL midop_reset: got busy=%b valid=%b ready=%b res=%h required 0/0/1/0",
                        bus.busy, bus.out_valid, bus.in_ready, bus.out_result);
    end
    @(negedge clk) rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL spurious_result: got %0d active cycles required 0", spurious); end

    send(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    collect(r, l, ok);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    n_cmp++; if (!ok || r !== e) begin n_bad++; $display("FAIL after_reset_mulhu: got %h required %h", r, e); end
    n_cmp++; if (l !== el) begin n_bad++; $display("FAIL after_reset_latency: got %0d required %0d", l, el); end
    release_out();

    send(OP_MUL, 32'd6, 32'd7, 1'b0);
    collect(r, l, ok);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_done: got valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e, a, b;
    logic [2:0] op;
    int l, el;
    bit ok;
    send(OP_MUL, 32'd3, 32'd5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      collect(r, l, ok);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++; if (!ok || r !== e) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h required %h", k, r, e); end
      n_cmp++; if (l !== el) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", k, l, el); end
      if (k == 4) break;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom_range(1, 32'hFFFF);
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
      bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_no_accept_on_handshake[%0d]: got busy=%b ready=%b required 0/1", k, bus.busy, bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d]: got busy=%b required 1", k, bus.busy); end
    end
    release_out();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_flush_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer; sits beside the execute-stage ALU in the 3-stage core.
- Accepts one operation from decode/execute via valid/ready and runs a shift-add multiply or restoring divide over XLEN cycles.
- Returns the result via valid/ready and drives the pipeline stall while busy.
- Replaces the need for a wide combinational multiplier/divider in the single-cycle ALU path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept; high only in IDLE
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  XLEN  rs1 operand
- b  input  XLEN  rs2 operand
- flush  input  1  kill in-flight op (branch mispredict/trap)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_result  output  XLEN  result
- busy  output  1  high in BUSY or DONE; used as execute-stage stall

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async, any state, mid-operation included):
  - state=IDLE, counter=0, out_valid=0, out_result=0, busy=0, in_ready=1.
  - All internal accumulators cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && !flush: latch op, compute operand magnitudes and sign flags, counter=XLEN, go to BUSY.
  - flush in the same cycle as in_valid: flush wins, nothing accepted.
- BUSY: one iteration per cycle; counter decrements; at counter==1 the final iteration completes and the next state is DONE.
- Multiply: 2*XLEN-bit product from unsigned magnitudes, one shift-add step per cycle.
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - Product is negated at completion when the signs of the signed operands differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - DIV/REM: signed; quotient negated if operand signs differ; remainder takes the sign of the dividend.
- Divide by zero (b==0):
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = a.
  - Takes the full XLEN cycles unless the optional feature is enabled.
- Signed overflow (a=most-negative, b=-1): DIV = a, REM = 0.
- Latency: accept at edge N gives out_valid=1 after edge N+XLEN+1, i.e. 33 cycles for XLEN=32.
- DONE:
  - out_valid=1; out_result stable.
  - Stays in DONE until out_ready; the handshake cycle returns to IDLE with out_valid=0 next cycle.
  - No new accept in the handshake cycle; back-to-back ops are therefore spaced ≥1 IDLE cycle.
- flush in BUSY or DONE:
  - Next state IDLE, out_valid=0; the result is discarded.
  - out_result retains its old value and is don't-care.
- busy = (state != IDLE).
- out_valid is never asserted outside DONE.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero, signed overflow, and operations with a==0 or b==0 skip BUSY and go IDLE→DONE.
  - Latency becomes 1 cycle (out_valid after the edge following accept), with the same result values as above.
- Undefined: every operation takes the full XLEN+1 latency.

Decomposition:
- Shared header/package muldiv_pkg:
  - funct3 op encodings (MD_MUL..MD_REMU).
  - State encodings (S_IDLE, S_BUSY, S_DONE).
  - Helper predicates is_div(op) and is_signed_a/b(op).
- Sub-module muldiv_core: the iteration datapath (accumulator, shift, add/sub-restore, final sign fix).
  - Controlled by muldiv_seq via start/step/finish strobes.
  - muldiv_seq holds the FSM, counter and handshakes.

Test Plan:
- MULH a=0x80000000 b=0x80000000 → out_result=0x40000000 after 33 cycles; MUL same operands → 0x00000000.
- DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000; REM same operands → 0x00000000.
- DIVU a=0x12345678 b=0 → 0xFFFFFFFF; REMU a=7 b=0 → 0x00000007; with MULDIV_EARLY_OUT_EN, out_valid one cycle after accept.
- DIV a=0xFFFFFFF9 (-7) b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure: out_ready=0 for 10 cycles after DONE → out_valid and out_result held stable, in_ready=0, busy=1; release → IDLE, in_ready=1 next cycle.
- flush at iteration 5 of a MUL, then rst_n pulsed low mid-DIV → IDLE, out_valid=0 with no spurious result; subsequent MULHU 0xFFFFFFFF×2 → 0x00000001.
